dense_par: RTL and testbench

- Parametrised successor of the single-MAC fully-connected layer.
- Computes OUT_COUNT neurons over IN_COUNT inputs using PAR parallel MAC lanes: neurons are processed in groups of PAR, all lanes sharing each input read.
- Adds signed fixed-point scaling with saturation, an optional ReLU, and an argmax class output.
- Sits after the flatten buffer, driven by the AXIS wrapper; weights and biases come from external LUTs.

---
 rtl/dense_par.sv | 221 ++++++++++++++++++++++
 tb/tb_dense_par.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_par.sv
// Fully-connected layer with PAR parallel MAC lanes sharing each input read.
// Fixed-point rescale with saturation, optional ReLU and a running argmax.
module dense_par #(
   parameter int IN_COUNT         = 1600,
   parameter int OUT_COUNT        = 10,
   parameter int PAR              = 2,
   parameter int DATA_SIZE        = 32,
   parameter int FRAC_BITS        = 16,
   parameter int WEIGHT_ADR_WIDTH = 14,
   parameter int BIAS_ADR_WIDTH   = 4,
   parameter int IN_ADR_WIDTH     = 11,
   parameter int OUT_ADR_WIDTH    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        reluEn,
   output logic [WEIGHT_ADR_WIDTH-1:0] weightAdr,
   input  logic [PAR*DATA_SIZE-1:0]    weightData,
   output logic [BIAS_ADR_WIDTH-1:0]   biasAdr,
   input  logic [PAR*DATA_SIZE-1:0]    biasData,
   input  logic                        axisif_start,
   output logic                        axisif_done,
   output logic                        axisif_busy,
   output logic [IN_ADR_WIDTH-1:0]     axisif_bufferIn_adr,
   input  logic [DATA_SIZE-1:0]        axisif_bufferIn_data,
   output logic [OUT_ADR_WIDTH-1:0]    axisif_bufferOut_adr,
   output logic [DATA_SIZE-1:0]        axisif_bufferOut_data,
   output logic                        axisif_bufferOut_wr,
   output logic [OUT_ADR_WIDTH-1:0]    classIdx
);
   localparam int GROUPS = (OUT_COUNT + PAR - 1) / PAR;
   localparam int ACC_W  = 2*DATA_SIZE + $clog2(IN_COUNT);
   localparam int PW     = 2*DATA_SIZE;
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int IW     = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
   localparam int KW     = (PAR > 1) ? $clog2(PAR) : 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic [GW-1:0]               g_q, g_d;
   logic [IW-1:0]               i_q, i_d;
   logic [KW-1:0]               k_q, k_d;
   logic                        relu_q, relu_d;
   logic signed [ACC_W-1:0]     acc_q [PAR];
   logic signed [ACC_W-1:0]     acc_d [PAR];
   logic signed [DATA_SIZE-1:0] max_val_q, max_val_d;
   logic [OUT_ADR_WIDTH-1:0]    max_idx_q, max_idx_d;
   logic [OUT_ADR_WIDTH-1:0]    class_q, class_d;

   logic signed [DATA_SIZE-1:0] in_s;
   logic signed [DATA_SIZE-1:0] w_lane   [PAR];
   logic signed [DATA_SIZE-1:0] b_lane   [PAR];
   logic signed [PW-1:0]        prod     [PAR];
   logic signed [ACC_W-1:0]     prod_ext [PAR];
   logic signed [ACC_W-1:0]     bias_ext [PAR];
   logic signed [ACC_W-1:0]     shifted  [PAR];
   logic signed [DATA_SIZE-1:0] res      [PAR];
   logic signed [DATA_SIZE-1:0] res_sel;
   logic [OUT_ADR_WIDTH-1:0]    out_idx;

   // Per-lane product, bias alignment and rescale/saturate/ReLU of the finished sum.
   always_comb begin
      in_s = axisif_bufferIn_data;
      for (int k = 0; k < PAR; k++) begin
         w_lane[k]   = weightData[k*DATA_SIZE +: DATA_SIZE];
         b_lane[k]   = biasData[k*DATA_SIZE +: DATA_SIZE];
         prod[k]     = PW'(w_lane[k]) * PW'(in_s);
         prod_ext[k] = ACC_W'(prod[k]);
         bias_ext[k] = ACC_W'(b_lane[k]) <<< FRAC_BITS;
         shifted[k]  = acc_q[k] >>> FRAC_BITS;
         if (shifted[k] > SAT_MAX) begin
            res[k] = SAT_MAX[DATA_SIZE-1:0];
         end else if (shifted[k] < SAT_MIN) begin
            res[k] = SAT_MIN[DATA_SIZE-1:0];
         end else begin
            res[k] = shifted[k][DATA_SIZE-1:0];
         end
         if (relu_q && res[k][DATA_SIZE-1]) begin
            res[k] = '0;
         end
      end
   end

   always_comb begin
      res_sel = res[k_q];
      out_idx = OUT_ADR_WIDTH'(32'(g_q) * 32'(PAR) + 32'(k_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         g_q       <= '0;
         i_q       <= '0;
         k_q       <= '0;
         relu_q    <= 1'b0;
         max_val_q <= '0;
         max_idx_q <= '0;
         class_q   <= '0;
         for (int k = 0; k < PAR; k++) begin
            acc_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         i_q       <= i_d;
         k_q       <= k_d;
         relu_q    <= relu_d;
         max_val_q <= max_val_d;
         max_idx_q <= max_idx_d;
         class_q   <= class_d;
         for (int k = 0; k < PAR; k++) begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

   // The first MAC cycle sees the bias read issued in BIAS; later cycles see the previous input/weight read.
   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      i_d       = i_q;
      k_d       = k_q;
      relu_d    = relu_q;
      max_val_d = max_val_q;
      max_idx_d = max_idx_q;
      class_d   = class_q;
      for (int k = 0; k < PAR; k++) begin
         acc_d[k] = acc_q[k];
      end
      case (state_q)
         S_IDLE: begin
            if (axisif_start) begin
               relu_d  = reluEn;
               g_d     = '0;
               state_d = S_BIAS;
            end
         end
         S_BIAS: begin
            i_d     = '0;
            state_d = S_MAC;
         end
         S_MAC: begin
            for (int k = 0; k < PAR; k++) begin
               acc_d[k] = (i_q == '0) ? bias_ext[k] : acc_q[k] + prod_ext[k];
            end
            if (32'(i_q) == IN_COUNT - 1) begin
               state_d = S_DRAIN;
            end else begin
               i_d = i_q + IW'(1);
            end
         end
         S_DRAIN: begin
            for (int k = 0; k < PAR; k++) begin
               acc_d[k] = acc_q[k] + prod_ext[k];
            end
            k_d     = '0;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (out_idx == '0 || res_sel > max_val_q) begin
               max_val_d = res_sel;
               max_idx_d = out_idx;
            end
            if (32'(k_q) + 1 < PAR && 32'(out_idx) + 1 < OUT_COUNT) begin
               k_d = k_q + KW'(1);
            end else if (32'(g_q) + 1 < GROUPS) begin
               g_d     = g_q + GW'(1);
               state_d = S_BIAS;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            class_d = max_idx_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      weightAdr             = '0;
      biasAdr               = '0;
      axisif_bufferIn_adr   = '0;
      axisif_bufferOut_adr  = '0;
      axisif_bufferOut_data = '0;
      axisif_bufferOut_wr   = 1'b0;
      axisif_done           = 1'b0;
      axisif_busy           = 1'b0;
      case (state_q)
         S_BIAS: begin
            biasAdr     = BIAS_ADR_WIDTH'(g_q);
            axisif_busy = 1'b1;
         end
         S_MAC: begin
            weightAdr           = WEIGHT_ADR_WIDTH'(32'(g_q) * 32'(IN_COUNT) + 32'(i_q));
            axisif_bufferIn_adr = IN_ADR_WIDTH'(i_q);
            axisif_busy         = 1'b1;
         end
         S_DRAIN: begin
            axisif_busy = 1'b1;
         end
         S_WRITE: begin
            axisif_bufferOut_wr   = 1'b1;
            axisif_bufferOut_adr  = out_idx;
            axisif_bufferOut_data = res_sel;
            axisif_busy           = 1'b1;
         end
         S_DONE: begin
            axisif_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign classIdx = class_q;

endmodule

// File: tb/tb_dense_par.sv
// Bench for dense_par: directed vector table, start/reset corner sequences and
// randomized passes compared against a plain-arithmetic model of the layer.
`timescale 1ns/1ps
module tb_dense_par;
   localparam int IN_COUNT         = 4;
   localparam int OUT_COUNT        = 5;
   localparam int PAR              = 2;
   localparam int DATA_SIZE        = 32;
   localparam int FRAC_BITS        = 16;
   localparam int WEIGHT_ADR_WIDTH = 14;
   localparam int BIAS_ADR_WIDTH   = 4;
   localparam int IN_ADR_WIDTH     = 11;
   localparam int OUT_ADR_WIDTH    = 4;
   localparam int GROUPS           = (OUT_COUNT + PAR - 1) / PAR;
   localparam int LATENCY          = 1 + GROUPS*(IN_COUNT+2) + OUT_COUNT;
   localparam int MAX_WAIT         = 200;
   localparam int NUM_VECS         = 6;
   localparam int NUM_RANDOM       = 8;
   localparam logic signed [127:0] ONE  = 128'sd65536;
   localparam logic signed [127:0] MAXV = 128'sd2147483647;
   localparam logic signed [127:0] MINV = -128'sd2147483648;

   typedef logic [OUT_COUNT-1:0][DATA_SIZE-1:0] outv_t;
   typedef struct {
      int    mode;
      bit    relu;
      outv_t expOut;
      int    expClass;
   } vec_t;
   typedef struct {
      logic [OUT_ADR_WIDTH-1:0] adr;
      logic [DATA_SIZE-1:0]     data;
   } wr_t;

   logic                        clk;
   logic                        rst;
   logic                        reluEn;
   logic [WEIGHT_ADR_WIDTH-1:0] weightAdr;
   logic [PAR*DATA_SIZE-1:0]    weightData;
   logic [BIAS_ADR_WIDTH-1:0]   biasAdr;
   logic [PAR*DATA_SIZE-1:0]    biasData;
   logic                        axisif_start;
   logic                        axisif_done;
   logic                        axisif_busy;
   logic [IN_ADR_WIDTH-1:0]     axisif_bufferIn_adr;
   logic [DATA_SIZE-1:0]        axisif_bufferIn_data;
   logic [OUT_ADR_WIDTH-1:0]    axisif_bufferOut_adr;
   logic [DATA_SIZE-1:0]        axisif_bufferOut_data;
   logic                        axisif_bufferOut_wr;
   logic [OUT_ADR_WIDTH-1:0]    classIdx;

   logic [DATA_SIZE-1:0] inMem [IN_COUNT];
   logic [DATA_SIZE-1:0] wMem  [OUT_COUNT][IN_COUNT];
   logic [DATA_SIZE-1:0] bMem  [OUT_COUNT];
   wr_t                  wrQ[$];
   vec_t                 vecs[NUM_VECS];
   int                   nChecks;
   int                   nErrors;

   dense_par #(
      .IN_COUNT(IN_COUNT), .OUT_COUNT(OUT_COUNT), .PAR(PAR), .DATA_SIZE(DATA_SIZE),
      .FRAC_BITS(FRAC_BITS), .WEIGHT_ADR_WIDTH(WEIGHT_ADR_WIDTH),
      .BIAS_ADR_WIDTH(BIAS_ADR_WIDTH), .IN_ADR_WIDTH(IN_ADR_WIDTH),
      .OUT_ADR_WIDTH(OUT_ADR_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .reluEn(reluEn),
      .weightAdr(weightAdr), .weightData(weightData),
      .biasAdr(biasAdr), .biasData(biasData),
      .axisif_start(axisif_start), .axisif_done(axisif_done), .axisif_busy(axisif_busy),
      .axisif_bufferIn_adr(axisif_bufferIn_adr), .axisif_bufferIn_data(axisif_bufferIn_data),
      .axisif_bufferOut_adr(axisif_bufferOut_adr), .axisif_bufferOut_data(axisif_bufferOut_data),
      .axisif_bufferOut_wr(axisif_bufferOut_wr), .classIdx(classIdx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous LUT/buffer models: weight address g*IN_COUNT+i, lane k holds neuron g*PAR+k.
   always @(posedge clk) begin : lutModel
      int g, i, n, idx;
      g   = int'(weightAdr) / IN_COUNT;
      i   = int'(weightAdr) % IN_COUNT;
      idx = int'(axisif_bufferIn_adr);
      axisif_bufferIn_data <= (idx < IN_COUNT) ? inMem[idx] : '0;
      for (int k = 0; k < PAR; k++) begin
         n = g*PAR + k;
         weightData[k*DATA_SIZE +: DATA_SIZE] <= (n < OUT_COUNT) ? wMem[n][i] : '0;
         n = int'(biasAdr)*PAR + k;
         biasData[k*DATA_SIZE +: DATA_SIZE] <= (n < OUT_COUNT) ? bMem[n] : '0;
      end
   end

   always @(negedge clk) begin : wrMonitor
      wr_t w;
      if (axisif_bufferOut_wr === 1'b1) begin
         w.adr  = axisif_bufferOut_adr;
         w.data = axisif_bufferOut_data;
         wrQ.push_back(w);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic loadMode(input int mode);
      int tie[OUT_COUNT];
      tie = '{1, 3, 2, 3, 1};
      for (int n = 0; n < OUT_COUNT; n++) begin
         bMem[n] = '0;
         if (mode == 1 && n == 2) bMem[n] = 32'hFF9C0000;
         for (int i = 0; i < IN_COUNT; i++) begin
            case (mode)
               0: begin inMem[i] = 32'h00010000; wMem[n][i] = 32'((n+1) << 16); end
               1: begin inMem[i] = 32'h00010000; wMem[n][i] = 32'h00010000; end
               3: begin inMem[i] = 32'h7FFFFFFF; wMem[n][i] = 32'h7FFFFFFF; end
               4: begin inMem[i] = 32'h7FFFFFFF; wMem[n][i] = 32'h80000001; end
               default: begin inMem[i] = 32'h00010000; wMem[n][i] = 32'(tie[n] << 16); end
            endcase
         end
      end
   endtask

   function automatic logic [DATA_SIZE-1:0] rndVal(input bit big);
      logic signed [19:0] s;
      s = 20'($urandom);
      return big ? DATA_SIZE'($urandom) : DATA_SIZE'(s);
   endfunction

   // Real-valued neuron: bias*2^F plus the sum of products, floor-divided by 2^F, clamped, ReLU, argmax.
   task automatic refModel(input bit relu, output outv_t expOut, output int expClass);
      logic signed [127:0]          acc, r;
      logic signed [DATA_SIZE-1:0]  v, best;
      best     = '0;
      expClass = 0;
      for (int n = 0; n < OUT_COUNT; n++) begin
         acc = 128'($signed(bMem[n])) * ONE;
         for (int i = 0; i < IN_COUNT; i++) begin
            acc = acc + 128'($signed(inMem[i])) * 128'($signed(wMem[n][i]));
         end
         r = acc / ONE;
         if (acc < 0 && (acc % ONE) != 0) r = r - 1;
         if (r > MAXV)      v = 32'h7FFFFFFF;
         else if (r < MINV) v = 32'h80000000;
         else               v = r[DATA_SIZE-1:0];
         if (relu && v < 0) v = '0;
         expOut[n] = v;
         if (n == 0 || v > best) begin
            best     = v;
            expClass = n;
         end
      end
   endtask

   // Pulses start at the current negedge and returns at the negedge after the done cycle.
   task automatic applyStimulus(input bit relu, output int lat);
      wrQ.delete();
      reluEn       = relu;
      axisif_start = 1'b1;
      @(negedge clk);
      axisif_start = 1'b0;
      reluEn       = ~relu;
      checkOutput("busy_after_start", axisif_busy, 1);
      lat = 1;
      while (axisif_done !== 1'b1 && lat < MAX_WAIT) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("busy_at_done", axisif_busy, 0);
      @(negedge clk);
   endtask

   task automatic checkRun(input string tag, input int lat, input outv_t expOut, input int expClass);
      checkOutput({tag, "_latency"}, lat, LATENCY);
      checkOutput({tag, "_wr_count"}, wrQ.size(), OUT_COUNT);
      for (int n = 0; n < OUT_COUNT; n++) begin
         if (n < wrQ.size()) begin
            checkOutput($sformatf("%s_adr%0d", tag, n), wrQ[n].adr, n);
            checkOutput($sformatf("%s_data%0d", tag, n), wrQ[n].data, expOut[n]);
         end
      end
      checkOutput({tag, "_classIdx"}, classIdx, expClass);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_busy"}, axisif_busy, 0);
      checkOutput({tag, "_done"}, axisif_done, 0);
      checkOutput({tag, "_wr"}, axisif_bufferOut_wr, 0);
      checkOutput({tag, "_weightAdr"}, weightAdr, 0);
      checkOutput({tag, "_biasAdr"}, biasAdr, 0);
      checkOutput({tag, "_inAdr"}, axisif_bufferIn_adr, 0);
      checkOutput({tag, "_outAdr"}, axisif_bufferOut_adr, 0);
      checkOutput({tag, "_outData"}, axisif_bufferOut_data, 0);
      checkOutput({tag, "_classIdx"}, classIdx, 0);
   endtask

   initial begin
      int    lat, cyc, doneCnt, firstDone;
      bit    big, relu;
      outv_t expOut;
      int    expClass;

      nChecks      = 0;
      nErrors      = 0;
      rst          = 1'b1;
      axisif_start = 1'b0;
      reluEn       = 1'b0;

      vecs[0] = '{mode: 0, relu: 1'b0, expClass: 4,
                  expOut: {32'h00140000, 32'h00100000, 32'h000C0000, 32'h00080000, 32'h00040000}};
      vecs[1] = '{mode: 1, relu: 1'b1, expClass: 0,
                  expOut: {32'h00040000, 32'h00040000, 32'h00000000, 32'h00040000, 32'h00040000}};
      vecs[2] = '{mode: 1, relu: 1'b0, expClass: 0,
                  expOut: {32'h00040000, 32'h00040000, 32'hFFA00000, 32'h00040000, 32'h00040000}};
      vecs[3] = '{mode: 3, relu: 1'b0, expClass: 0,
                  expOut: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}};
      vecs[4] = '{mode: 4, relu: 1'b0, expClass: 0,
                  expOut: {32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000}};
      vecs[5] = '{mode: 5, relu: 1'b0, expClass: 1,
                  expOut: {32'h00040000, 32'h000C0000, 32'h00080000, 32'h000C0000, 32'h00040000}};

      loadMode(0);
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Table runs are issued back to back: each start lands in the cycle after the previous done.
      for (int v = 0; v < NUM_VECS; v++) begin
         loadMode(vecs[v].mode);
         applyStimulus(vecs[v].relu, lat);
         checkRun($sformatf("vec%0d", v), lat, vecs[v].expOut, vecs[v].expClass);
      end

      // start toggled during the run must be ignored.
      loadMode(0);
      wrQ.delete();
      doneCnt      = 0;
      firstDone    = 0;
      reluEn       = 1'b0;
      axisif_start = 1'b1;
      for (int c = 1; c <= LATENCY + 15; c++) begin
         @(negedge clk);
         if (axisif_done === 1'b1) begin
            doneCnt++;
            if (firstDone == 0) firstDone = c;
         end
         axisif_start = (c < 16) ? c[0] : 1'b0;
      end
      checkOutput("rep_done_count", doneCnt, 1);
      checkRun("rep", firstDone, vecs[0].expOut, vecs[0].expClass);

      // Reset during group 1 MAC aborts the pass silently.
      loadMode(0);
      wrQ.delete();
      axisif_start = 1'b1;
      @(negedge clk);
      axisif_start = 1'b0;
      cyc = 1;
      while (int'(weightAdr) < IN_COUNT && cyc < MAX_WAIT) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("rst_reach_group1", cyc < MAX_WAIT, 1);
      checkOutput("rst_pre_writes", wrQ.size(), PAR);
      wrQ.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkIdleOutputs("midrun_rst");
      doneCnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (axisif_done === 1'b1) doneCnt++;
      end
      checkOutput("rst_no_done", doneCnt, 0);
      checkOutput("rst_no_writes", wrQ.size(), 0);
      applyStimulus(1'b0, lat);
      checkRun("after_rst", lat, vecs[0].expOut, vecs[0].expClass);

      for (int r = 0; r < NUM_RANDOM; r++) begin
         big  = ($urandom_range(0, 3) == 0);
         relu = 1'($urandom_range(0, 1));
         for (int n = 0; n < OUT_COUNT; n++) begin
            bMem[n] = rndVal(big);
            for (int i = 0; i < IN_COUNT; i++) begin
               wMem[n][i] = rndVal(big);
            end
         end
         for (int i = 0; i < IN_COUNT; i++) begin
            inMem[i] = rndVal(big);
         end
         refModel(relu, expOut, expClass);
         applyStimulus(relu, lat);
         checkRun($sformatf("rnd%0d", r), lat, expOut, expClass);
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
